// File: rtl/otp_stream_ctrl.sv
// One-time-pad stream controller: XORs a message with key words fetched one per beat, MSB chunk first.
// Optional zero-key detection is enabled with the OTP_ZERO_KEY_CHECK_EN macro (adds the key_err port).
module otp_stream_ctrl #(
    parameter int MSG_SIZE = 32,
    parameter int KEY_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [MSG_SIZE-1:0] msg,
    output logic                key_req,
    input  logic                key_valid,
    input  logic [KEY_SIZE-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MSG_SIZE-1:0] out,
    output logic                busy
`ifdef OTP_ZERO_KEY_CHECK_EN
    ,
    output logic                key_err
`endif
);

    localparam int BEATS = MSG_SIZE / KEY_SIZE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [MSG_SIZE-1:0] plain;
    logic [MSG_SIZE-1:0] cyph;
    logic [MSG_SIZE-1:0] cyph_next;
    logic [MSG_SIZE-1:0] out_reg;
    logic [KEY_SIZE-1:0] chunk;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                beat;
    logic                last_beat;
    logic                zero_out;

    assign accept    = (state == IDLE) && msg_valid;
    assign beat      = (state == RUN) && key_valid;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign chunk     = plain[MSG_SIZE-1 -: KEY_SIZE] ^ key;
    assign cyph_next = (cyph << KEY_SIZE) | MSG_SIZE'(chunk);
    assign out       = out_reg;

`ifdef OTP_ZERO_KEY_CHECK_EN
    logic key_err_q;
    assign key_err  = key_err_q;
    assign zero_out = key_err_q || (key == '0);
`else
    assign zero_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        msg_ready  = 1'b0;
        key_req    = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                msg_ready = 1'b1;
                busy      = 1'b0;
                if (msg_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                key_req = 1'b1;
                if (key_valid && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // The output register is loaded only on the final beat, so it keeps the
    // previous cyphertext through IDLE and the next message's RUN phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plain   <= '0;
            cyph    <= '0;
            cnt     <= '0;
            out_reg <= '0;
        end else if (accept) begin
            plain <= msg;
            cyph  <= '0;
            cnt   <= '0;
        end else if (beat) begin
            plain <= plain << KEY_SIZE;
            cyph  <= cyph_next;
            cnt   <= cnt + CNT_W'(1);
            if (last_beat) begin
                out_reg <= zero_out ? '0 : cyph_next;
            end
        end
    end

`ifdef OTP_ZERO_KEY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_err_q <= 1'b0;
        end else if (accept) begin
            key_err_q <= 1'b0;
        end else if (beat && (key == '0)) begin
            key_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/otp_stream_ctrl.md
Name: otp_stream_ctrl

Overview:
Controller that sequences one-time-pad encryption of a full `MSG_SIZE`-bit message using `KEY_SIZE`-bit key words fetched on demand.
- Accepts a message over a valid/ready handshake.
- Requests one key word per beat from an external key source.
- XORs each message chunk (MSB chunk first) with its key word and assembles the cyphertext.
- Presents the finished cyphertext over an output valid/ready handshake.
- Sits between the message producer, the key-stream source and the downstream consumer; replaces free-running enable-driven sequencing with explicit beat control.

Parameters:
- MSG_SIZE, 32, message and cyphertext width in bits.
- KEY_SIZE, 8, key word and chunk width; MSG_SIZE must be an integer multiple of KEY_SIZE.
- BEATS, MSG_SIZE/KEY_SIZE, derived; number of key words per message (not user-set).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- msg_valid  in  1  producer has a message.
- msg_ready  out  1  controller can accept a message.
- msg  in  MSG_SIZE  plaintext, sampled on msg_valid&&msg_ready.
- key_req  out  1  request for the next key word.
- key_valid  in  1  key word present on key.
- key  in  KEY_SIZE  key word, consumed on key_req&&key_valid.
- out_valid  out  1  cyphertext available.
- out_ready  in  1  consumer accepts cyphertext.
- out  out  MSG_SIZE  cyphertext, stable while out_valid.
- busy  out  1  high in RUN or DONE.
- key_err  out  1  present only with OTP_ZERO_KEY_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (async, immediate): state=IDLE, msg_ready=1, key_req=0, out_valid=0, out=0, busy=0, beat counter=0, key_err=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - msg_ready=1.
  - On msg_valid: latch msg into the plaintext shift register, clear the cyphertext register and the beat counter, go to RUN.
- RUN:
  - key_req=1, msg_ready=0.
  - Each cycle with key_valid=1 is one beat:
    - chunk = plaintext[MSG_SIZE-1 -: KEY_SIZE] ^ key.
    - Cyphertext shifts left by KEY_SIZE with chunk in the low bits.
    - Plaintext shifts left by KEY_SIZE.
    - Counter increments.
  - key_valid=0 stalls: no state change.
  - On the beat where counter==BEATS-1, go to DONE; key_req drops the cycle after.
- DONE:
  - out_valid=1, out holds the cyphertext, key_req=0.
  - Hold indefinitely until out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - out retains its last value in IDLE.
- Latency: msg accepted at edge 0. With key_valid held high, beats occur at edges 1..BEATS and out_valid is high after edge BEATS. Every key_valid gap adds one cycle.
- Ordering: the first key word covers the MSB chunk; the final cyphertext bit order matches plaintext order.
- Back-to-back: no new message is accepted in DONE. msg_ready is first high in the cycle after the out handshake, giving a minimum of one idle cycle between messages.
- Simultaneous events:
  - msg_valid outside IDLE is ignored.
  - key_valid outside RUN is ignored; no key word is consumed.
- Reset mid-RUN or mid-DONE: partial cyphertext is discarded and already-consumed key words are not replayed.
- Key words are used exactly once; the controller never re-issues key_req for a consumed word.

Optional Feature:
Macro: OTP_ZERO_KEY_CHECK_EN.
- Enabled:
  - An all-zero key word consumed in RUN sets key_err=1 (sticky until reset or the next msg accept).
  - The beat still completes.
  - In DONE, out is forced to all zeros.
- Disabled:
  - key_err port absent.
  - Zero keys are processed normally (chunk passes unchanged).

Test Plan:
- Basic (MSG_SIZE 32, KEY_SIZE 8): msg=0x12345678, keys FF,00,AA,55 with key_valid always high -> out=0xED34FC2D, out_valid rises after edge 4 from acceptance.
- Key stall: same stimulus with key_valid low for 3 cycles before the third key -> out=0xED34FC2D, out_valid delayed by exactly 3 cycles; key_req stays high during the stall.
- Output backpressure: out_ready low for 5 cycles in DONE -> out_valid and out hold 0xED34FC2D, msg_ready=0, key_req=0; IDLE is entered after out_ready.
- Ignored inputs: msg_valid pulsed during RUN with 0xFFFFFFFF -> result unchanged. key_valid pulsed in IDLE -> no key consumed, counter stays 0.
- Reset mid-RUN: rst asserted after 2 beats -> outputs at reset values immediately. The next message 0x00000000 with keys 01,02,03,04 -> out=0x01020304.
- With OTP_ZERO_KEY_CHECK_EN: keys FF,00,AA,55 -> key_err=1 after the second beat, out=0x00000000. Without the macro, the same stimulus gives 0xED34FC2D.
